// File: rtl/pio_fifo_pkg.sv
// pio_fifo_pkg: shared mode encodings, mover FSM states and FIFO geometry
// for the PIO per-state-machine FIFO controller.
package pio_fifo_pkg;

  localparam logic [1:0] MODE_NORMAL  = 2'b00;
  localparam logic [1:0] MODE_JOIN_TX = 2'b01;
  localparam logic [1:0] MODE_JOIN_RX = 2'b10;

  localparam int FIFO_DEPTH = 4;

  typedef enum logic {
    MV_IDLE = 1'b0,
    MV_MOVE = 1'b1
  } mover_state_e;

  // The reserved encoding 2'b11 behaves exactly like normal mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    if (m == 2'b11) begin
      return MODE_NORMAL;
    end else begin
      return m;
    end
  endfunction

endpackage

// File: rtl/fifo.sv
// fifo: DEPTH-entry synchronous FIFO with registered read data and a
// one-cycle valid strobe. A push wins over a pull in the same cycle; the
// losing pull is not accepted and the requester has to retry.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  input  logic             pull_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             push_ok_s;
  logic             pull_ok_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok_s = push_i & ~full_o;
  assign pull_ok_s = pull_i & ~empty_o & ~push_ok_s;
  assign dout_o    = dout_q;
  assign valid_o   = valid_q;

  // Storage, pointers, occupancy and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      valid_q <= pull_ok_s;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
        count_q         <= count_q + CW'(1);
      end else if (pull_ok_s) begin
        dout_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        count_q  <= count_q - CW'(1);
      end else begin
        count_q <= count_q;
      end
    end
  end

endmodule

// File: rtl/fifo_join_ctrl.sv
// fifo_join_ctrl: owns FIFOs A and B and presents them either as separate
// 4-deep TX/RX queues or as one 8-deep queue (tail -> mover -> head) in a
// single direction. A mode change costs one flush cycle that empties both.
module fifo_join_ctrl
  import pio_fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             tx_push,
  input  logic [WIDTH-1:0] tx_din,
  output logic             tx_full,
  input  logic             tx_pull,
  output logic [WIDTH-1:0] tx_dout,
  output logic             tx_valid,
  output logic             tx_empty,
  input  logic             rx_push,
  input  logic [WIDTH-1:0] rx_din,
  output logic             rx_full,
  input  logic             rx_pull,
  output logic [WIDTH-1:0] rx_dout,
  output logic             rx_valid,
  output logic             rx_empty,
  output logic             busy
);

  mover_state_e     state_q;
  logic [1:0]       mode_q;

  logic [1:0]       eff_mode_s;
  logic             flush_s;
  logic             fifo_srst_s;
  logic             joined_s;
  logic             tail_full_s;
  logic             tail_empty_s;
  logic             head_full_s;
  logic             head_empty_s;
  logic             host_push_s;
  logic             cons_pull_s;
  logic             host_push_ok_s;
  logic             cons_pull_ok_s;
  logic             mover_pull_s;
  logic             mover_push_s;

  logic             a_push_s, a_pull_s, a_full_s, a_empty_s, a_valid_s;
  logic             b_push_s, b_pull_s, b_full_s, b_empty_s, b_valid_s;
  logic [WIDTH-1:0] a_din_s, a_dout_s, b_din_s, b_dout_s;

  assign fifo_srst_s = ~reset | flush_s;
  assign busy        = (state_q == MV_MOVE);

  // Mode decode and the mover's pull/push decisions for this cycle.
  always_comb begin
    eff_mode_s   = norm_mode(mode);
    flush_s      = (eff_mode_s != mode_q);
    joined_s     = (mode_q == MODE_JOIN_TX) || (mode_q == MODE_JOIN_RX);
    tail_full_s  = 1'b0;
    tail_empty_s = 1'b1;
    head_full_s  = 1'b0;
    head_empty_s = 1'b1;
    host_push_s  = 1'b0;
    cons_pull_s  = 1'b0;
    case (mode_q)
      MODE_JOIN_TX: begin
        tail_full_s  = b_full_s;
        tail_empty_s = b_empty_s;
        head_full_s  = a_full_s;
        head_empty_s = a_empty_s;
        host_push_s  = tx_push;
        cons_pull_s  = tx_pull;
      end
      MODE_JOIN_RX: begin
        tail_full_s  = a_full_s;
        tail_empty_s = a_empty_s;
        head_full_s  = b_full_s;
        head_empty_s = b_empty_s;
        host_push_s  = rx_push;
        cons_pull_s  = rx_pull;
      end
      default: begin
        host_push_s = 1'b0;
      end
    endcase
    host_push_ok_s = host_push_s & ~tail_full_s;
    cons_pull_ok_s = cons_pull_s & ~head_empty_s;
    // The tail pull must not collide with an accepted producer push.
    mover_pull_s   = ~flush_s & joined_s & (state_q == MV_IDLE) &
                     ~tail_empty_s & ~head_full_s & ~host_push_ok_s;
    // The head consumer wins; the mover holds its word until a free cycle.
    mover_push_s   = ~flush_s & joined_s & (state_q == MV_MOVE) & ~cons_pull_ok_s;
  end

  // Route requests to the physical FIFOs; nothing moves in a flush cycle.
  always_comb begin
    a_push_s = 1'b0;
    a_pull_s = 1'b0;
    a_din_s  = '0;
    b_push_s = 1'b0;
    b_pull_s = 1'b0;
    b_din_s  = '0;
    if (flush_s) begin
      a_push_s = 1'b0;
    end else begin
      case (mode_q)
        MODE_NORMAL: begin
          a_push_s = tx_push;
          a_din_s  = tx_din;
          a_pull_s = tx_pull;
          b_push_s = rx_push;
          b_din_s  = rx_din;
          b_pull_s = rx_pull;
        end
        MODE_JOIN_TX: begin
          b_push_s = tx_push;
          b_din_s  = tx_din;
          b_pull_s = mover_pull_s;
          a_push_s = mover_push_s;
          a_din_s  = b_dout_s;
          a_pull_s = tx_pull;
        end
        MODE_JOIN_RX: begin
          a_push_s = rx_push;
          a_din_s  = rx_din;
          a_pull_s = mover_pull_s;
          b_push_s = mover_push_s;
          b_din_s  = a_dout_s;
          b_pull_s = rx_pull;
        end
        default: begin
          a_push_s = 1'b0;
        end
      endcase
    end
  end

  // Present the head/tail status on each side; a disabled side reads full and empty.
  always_comb begin
    tx_full  = 1'b1;
    tx_empty = 1'b1;
    tx_valid = 1'b0;
    tx_dout  = '0;
    rx_full  = 1'b1;
    rx_empty = 1'b1;
    rx_valid = 1'b0;
    rx_dout  = '0;
    case (mode_q)
      MODE_JOIN_TX: begin
        tx_full  = b_full_s;
        tx_empty = a_empty_s;
        tx_valid = a_valid_s;
        tx_dout  = a_dout_s;
      end
      MODE_JOIN_RX: begin
        rx_full  = a_full_s;
        rx_empty = b_empty_s;
        rx_valid = b_valid_s;
        rx_dout  = b_dout_s;
      end
      default: begin
        tx_full  = a_full_s;
        tx_empty = a_empty_s;
        tx_valid = a_valid_s;
        tx_dout  = a_dout_s;
        rx_full  = b_full_s;
        rx_empty = b_empty_s;
        rx_valid = b_valid_s;
        rx_dout  = b_dout_s;
      end
    endcase
  end

  // Mover FSM and registered mode; a mode change flushes back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MV_IDLE;
      mode_q  <= MODE_NORMAL;
    end else if (flush_s) begin
      state_q <= MV_IDLE;
      mode_q  <= eff_mode_s;
    end else begin
      case (state_q)
        MV_IDLE: begin
          if (mover_pull_s) state_q <= MV_MOVE;
          else              state_q <= MV_IDLE;
        end
        MV_MOVE: begin
          if (mover_push_s) state_q <= MV_IDLE;
          else              state_q <= MV_MOVE;
        end
        default: state_q <= MV_IDLE;
      endcase
    end
  end

  fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst_n   (reset),
    .srst_i  (fifo_srst_s),
    .push_i  (a_push_s),
    .din_i   (a_din_s),
    .full_o  (a_full_s),
    .pull_i  (a_pull_s),
    .dout_o  (a_dout_s),
    .valid_o (a_valid_s),
    .empty_o (a_empty_s)
  );

  fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst_n   (reset),
    .srst_i  (fifo_srst_s),
    .push_i  (b_push_s),
    .din_i   (b_din_s),
    .full_o  (b_full_s),
    .pull_i  (b_pull_s),
    .dout_o  (b_dout_s),
    .valid_o (b_valid_s),
    .empty_o (b_empty_s)
  );

endmodule
